// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } uart_rx_state_t;

   localparam int unsigned UART_DATA_W = 8;

   // Baud-count value at which the start bit is re-checked (mid start bit).
   function automatic int unsigned uart_half(input int unsigned clks_per_bit);
      return clks_per_bit / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
interface uart_rx_if #(
   parameter int unsigned DATA_W = 8
);

   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;

   modport master (
      output o_data,
      output o_valid,
      input  i_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      output i_ready
   );

endinterface

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous level input; resets to the idle-high level.
module uart_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start / DATA_W data (LSB first) / 1 stop, mid-bit sampling,
// false-start rejection, framing check and a single-entry valid/ready holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_W       = UART_DATA_W,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_uart_rx,
   uart_rx_if.master rx_if,
   output logic      o_frame_err,
   output logic      o_overrun,
   output logic      o_busy
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_W);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(uart_half(CLKS_PER_BIT));
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   logic              w_rx_s;
   logic              r_rx_prev;
   logic              w_fall;

   uart_rx_state_t    r_state;
   uart_rx_state_t    w_state_d;
   logic [BAUD_W-1:0] r_baud;
   logic [BAUD_W-1:0] w_baud_d;
   logic [BAUD_W-1:0] w_baud_inc;
   logic              w_baud_last;
   logic [BIT_W-1:0]  r_bit;
   logic [BIT_W-1:0]  w_bit_d;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shreg_d;
   logic              w_good;
   logic              w_bad;

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_frame_err;
   logic              r_overrun;

   uart_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_uart_rx),
      .o_sync  (w_rx_s)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_prev <= w_rx_s;
      end
   end

   assign w_fall      = r_rx_prev & ~w_rx_s;
   assign w_baud_last = (r_baud == BAUD_LAST);
   assign w_baud_inc  = w_baud_last ? '0 : r_baud + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RX_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shreg <= '0;
      end else begin
         r_state <= w_state_d;
         r_baud  <= w_baud_d;
         r_bit   <= w_bit_d;
         r_shreg <= w_shreg_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_baud_d  = r_baud;
      w_bit_d   = r_bit;
      w_shreg_d = r_shreg;
      w_good    = 1'b0;
      w_bad     = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_baud_d = '0;
            if (w_fall) begin
               w_state_d = RX_START;
            end
         end
         RX_START: begin
            w_baud_d = w_baud_inc;
            if (r_baud == BAUD_HALF) begin
               w_baud_d = '0;
               if (!w_rx_s) begin
                  w_state_d = RX_DATA;
                  w_bit_d   = '0;
               end else begin
                  w_state_d = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            w_baud_d = w_baud_inc;
            if (w_baud_last) begin
               w_shreg_d = {w_rx_s, r_shreg[DATA_W-1:1]};
               if (r_bit == BIT_LAST) begin
                  w_state_d = RX_STOP;
               end else begin
                  w_bit_d = r_bit + 1'b1;
               end
            end
         end
         RX_STOP: begin
            w_baud_d = w_baud_inc;
            // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
            if (w_baud_last) begin
               w_state_d = RX_IDLE;
               w_good    = w_rx_s;
               w_bad     = ~w_rx_s;
            end
         end
         default: begin
            w_state_d = RX_IDLE;
         end
      endcase
   end

   // Holding register: a completing frame may replace a byte consumed in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_bad;
         r_overrun   <= w_good & r_valid & ~rx_if.i_ready;
         if (w_good && (!r_valid || rx_if.i_ready)) begin
            r_data  <= r_shreg;
            r_valid <= 1'b1;
         end else if (r_valid && rx_if.i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_if.o_data  = r_data;
   assign rx_if.o_valid = r_valid;
   assign o_frame_err   = r_frame_err;
   assign o_overrun     = r_overrun;
   assign o_busy        = (r_state != RX_IDLE);

   a_flags_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(r_frame_err && r_overrun));

   a_data_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (r_valid && !rx_if.i_ready) |=> (r_valid && $stable(r_data)));

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level scoreboard model checked every cycle, plus literal checks.
module tb_uart_rx;

   localparam int unsigned CPB  = 16;
   localparam int unsigned DW   = 8;
   localparam int unsigned SYNC = 2;

   // Offsets in cycles from the cycle the start edge is driven onto the line.
   localparam int BUSY_OFS  = SYNC + 1;
   localparam int DONE_OFS  = 9 * CPB + SYNC + CPB / 2 + 1;
   localparam int FALSE_END = SYNC + 1 + (CPB / 2 - 1) + 1;

   typedef struct {
      int         t;
      logic [7:0] b;
      logic       stop;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic line  = 1'b1;
   int   cyc   = 0;

   logic frame_err;
   logic overrun;
   logic busy;

   uart_rx_if #(.DATA_W(DW)) bus ();

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_W       (DW),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_uart_rx   (line),
      .rx_if       (bus),
      .o_frame_err (frame_err),
      .o_overrun   (overrun),
      .o_busy      (busy)
   );

   ev_t        ev_q[$];
   logic [7:0] acc_q[$];
   logic       m_held = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_ferr = 1'b0;
   logic       m_ovr  = 1'b0;
   int         b_from = 0;
   int         b_to   = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt  = 0;
   int         n_err = 0;
   int         n_chk = 0;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Model: checks this cycle's outputs, then advances to the next clock edge.
   initial begin
      ev_t  e;
      logic exp_busy;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ev_q.delete();
            m_held = 1'b0;
            m_data = 8'h00;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            b_to   = 0;
            chk("in_reset", {busy, overrun, frame_err, bus.o_valid, bus.o_data}, 0);
         end else begin
            exp_busy = (cyc >= b_from) && (cyc < b_to);
            chk("cycle", {busy, overrun, frame_err, bus.o_valid, bus.o_data},
                {exp_busy, m_ovr, m_ferr, m_held, m_data});
            if (bus.o_valid && bus.i_ready) acc_q.push_back(bus.o_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].t == cyc + 1) begin
               e = ev_q.pop_front();
               if (!e.stop) begin
                  m_ferr = 1'b1;
               end else if (m_held && !bus.i_ready) begin
                  m_ovr = 1'b1;
               end else begin
                  m_held = 1'b1;
                  m_data = e.b;
               end
            end else if (m_held && bus.i_ready) begin
               m_held = 1'b0;
            end
         end
      end
   end

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      line = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      ev_t e;
      e.t    = cyc + DONE_OFS;
      e.b    = b;
      e.stop = stop;
      ev_q.push_back(e);
      b_from = cyc + BUSY_OFS;
      b_to   = cyc + DONE_OFS;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      line = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      logic [7:0] part;
      bus.i_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_values", {busy, overrun, frame_err, bus.o_valid, bus.o_data}, 0);
      rst_n = 1'b1;
      idle(5);

      // Plain frame, consumer always ready.
      send_frame(8'hA5, 1'b1);
      idle(20);
      chk("a5_count", acc_q.size(), 1);
      chk("a5_data", acc_q[0], 8'hA5);
      chk("a5_flags", ferr_cnt + ovr_cnt, 0);

      // False start: short low glitch.
      b_from = cyc + BUSY_OFS;
      b_to   = cyc + FALSE_END;
      line   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      chk("false_start_count", acc_q.size(), 1);
      chk("false_start_flags", ferr_cnt + ovr_cnt, 0);

      // Framing error, then a good frame.
      send_frame(8'h3C, 1'b0);
      idle(20);
      chk("ferr_count", ferr_cnt, 1);
      chk("ferr_no_valid", acc_q.size(), 1);
      send_frame(8'h3C, 1'b1);
      idle(20);
      chk("after_ferr_count", acc_q.size(), 2);
      chk("after_ferr_data", acc_q[1], 8'h3C);

      // Overrun while consumer stalls.
      bus.i_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(20);
      chk("ovr_count", ovr_cnt, 1);
      chk("ovr_hold", {bus.o_valid, bus.o_data}, {1'b1, 8'h11});
      bus.i_ready = 1'b1;
      idle(3);
      chk("ovr_consume_count", acc_q.size(), 3);
      chk("ovr_consume_data", acc_q[2], 8'h11);
      chk("ovr_valid_fall", bus.o_valid, 1'b0);

      // Back-to-back frames.
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      chk("b2b_count", acc_q.size(), 5);
      chk("b2b_first", acc_q[3], 8'h00);
      chk("b2b_second", acc_q[4], 8'hFF);

      // Back-to-back with ready pulsed exactly in the second frame's delivery cycle.
      bus.i_ready = 1'b0;
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
         end
         begin
            repeat (10 * CPB + DONE_OFS - 1) @(posedge clk);
            #1 bus.i_ready = 1'b1;
            @(posedge clk);
            #1 bus.i_ready = 1'b0;
         end
      join
      idle(20);
      chk("pulse_no_ovr", ovr_cnt, 1);
      chk("pulse_held", {bus.o_valid, bus.o_data}, {1'b1, 8'hFF});
      bus.i_ready = 1'b1;
      idle(3);
      chk("pulse_count", acc_q.size(), 7);
      chk("pulse_first", acc_q[5], 8'h00);
      chk("pulse_second", acc_q[6], 8'hFF);

      // Reset in data bit 3 with a byte held; both must be discarded.
      bus.i_ready = 1'b0;
      send_frame(8'h77, 1'b1);
      idle(10);
      part   = 8'hC3;
      b_from = cyc + BUSY_OFS;
      b_to   = cyc + DONE_OFS;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(part[i]);
      line = part[3];
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      line  = 1'b1;
      #1;
      chk("async_reset", {busy, overrun, frame_err, bus.o_valid, bus.o_data}, 0);
      repeat (4) @(posedge clk);
      #1;
      rst_n       = 1'b1;
      bus.i_ready = 1'b1;
      idle(10);
      send_frame(8'h5A, 1'b1);
      idle(20);
      chk("post_reset_count", acc_q.size(), 8);
      chk("post_reset_data", acc_q[7], 8'h5A);
      chk("final_ferr", ferr_cnt, 1);
      chk("final_ovr", ovr_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
